// File: rtl/riscv_rsb.sv
// Return stack buffer: decodes fetched call/return hints, keeps DEPTH return addresses.
// Define RISCV_RSB_OVERWRITE_EN to overwrite the oldest entry on a push when full.
module riscv_rsb #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int HAS_RVC = 0
) (
  input  logic            rst_ni,
  input  logic            clk_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_insn_i,
  output logic [XLEN-1:0] rsb_top_o,
  output logic [XLEN-1:0] rsb_pc_o,
  output logic            rsb_valid_o,
  output logic            rsb_empty_o,
  output logic            rsb_full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] mem_d [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic [4:0]      rd, rs1;
  logic            rd_link, rs1_link, is_jal, is_jalr, is_rvc, dec_en;
  logic            do_push, do_pop, do_poppush;
  logic            empty, full;
  logic [PW-1:0]   ptr_inc, ptr_dec;
  logic [XLEN-1:0] ret_addr;
  logic            unused_bits;

  assign unused_bits = ^{if_insn_i[31:20], if_insn_i[14:12]};

  // Compressed encodings only matter for length; they never reach the stack.
  assign is_rvc   = (HAS_RVC != 0) && (if_insn_i[1:0] != 2'b11);
  assign dec_en   = if_valid_i && !stall_i && !flush_i && !is_rvc && (if_insn_i[1:0] == 2'b11);
  assign rd       = if_insn_i[11:7];
  assign rs1      = if_insn_i[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jal   = (if_insn_i[6:0] == OP_JAL);
  assign is_jalr  = (if_insn_i[6:0] == OP_JALR);

  assign do_push    = dec_en && ((is_jal && rd_link) ||
                      (is_jalr && rd_link && (!rs1_link || (rd == rs1))));
  assign do_pop     = dec_en && is_jalr && !rd_link && rs1_link;
  assign do_poppush = dec_en && is_jalr && rd_link && rs1_link && (rd != rs1);

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign ptr_inc  = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign ret_addr = if_pc_i + XLEN'(4);

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!stall_i) begin
      valid_d = 1'b0;
      if (flush_i) begin
        ptr_d = '0;
        cnt_d = '0;
      end else if (do_pop) begin
        if (!empty) begin
          pc_d    = mem_q[ptr_q];
          valid_d = 1'b1;
          ptr_d   = ptr_dec;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          pc_d    = '0;
        end
      end else if (do_poppush && !empty) begin
        // Call-through-return: hand out the old top and reuse its slot.
        pc_d          = mem_q[ptr_q];
        valid_d       = 1'b1;
        mem_d[ptr_q]  = ret_addr;
      end else if (do_push || do_poppush) begin
        if (!full) begin
          ptr_d          = ptr_inc;
          mem_d[ptr_inc] = ret_addr;
          cnt_d          = cnt_q + 1'b1;
        end else begin
`ifdef RISCV_RSB_OVERWRITE_EN
          ptr_d          = ptr_inc;
          mem_d[ptr_inc] = ret_addr;
`else
          ptr_d          = ptr_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Array contents are qualified by cnt, so they need no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rsb_top_o   = empty ? '0 : mem_q[ptr_q];
  assign rsb_pc_o    = pc_q;
  assign rsb_valid_o = valid_q;
  assign rsb_empty_o = empty;
  assign rsb_full_o  = full;
endmodule

// File: tb/tb_riscv_rsb.sv
// Bench for riscv_rsb: directed steps plus random traffic against a queue-based stack model.
module tb_riscv_rsb;
  localparam int DEPTH = 4;

  logic        rst_ni, clk_i, stall_i, flush_i, if_valid_i;
  logic [31:0] if_pc_i, if_insn_i;
  logic [31:0] rsb_top_o, rsb_pc_o;
  logic        rsb_valid_o, rsb_empty_o, rsb_full_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [31:0] m_pc;
  logic        m_valid;

  riscv_rsb #(.XLEN(32), .DEPTH(DEPTH), .HAS_RVC(0)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .stall_i(stall_i), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_insn_i(if_insn_i),
    .rsb_top_o(rsb_top_o), .rsb_pc_o(rsb_pc_o), .rsb_valid_o(rsb_valid_o),
    .rsb_empty_o(rsb_empty_o), .rsb_full_o(rsb_full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs);
    return {12'h0, rs, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stack model: queue with the oldest entry at the front, newest at the back.
  task automatic model(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic st, input logic fl);
    logic [4:0] rd, rs;
    logic lrd, lrs;
    int op;
    if (st) return;
    m_valid = 1'b0;
    if (fl) begin q.delete(); return; end
    if (!v || insn[1:0] != 2'b11) return;
    rd = insn[11:7];
    rs = insn[19:15];
    lrd = (rd == 5'd1) || (rd == 5'd5);
    lrs = (rs == 5'd1) || (rs == 5'd5);
    op = 0;
    if (insn[6:0] == 7'h6f) begin
      if (lrd) op = 1;
    end else if (insn[6:0] == 7'h67) begin
      if (lrd && !lrs) op = 1;
      else if (!lrd && lrs) op = 2;
      else if (lrd && lrs) op = (rd == rs) ? 1 : 3;
    end
    if (op == 3 && q.size() == 0) op = 1;
    case (op)
      1: begin
        if (q.size() < DEPTH) q.push_back(pc + 32'd4);
        else begin
`ifdef RISCV_RSB_OVERWRITE_EN
          void'(q.pop_front());
          q.push_back(pc + 32'd4);
`endif
        end
      end
      2: begin
        if (q.size() > 0) begin m_pc = q.pop_back(); m_valid = 1'b1; end
        else m_pc = 32'h0;
      end
      3: begin
        m_pc = q[q.size()-1];
        q[q.size()-1] = pc + 32'd4;
        m_valid = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_top"},   rsb_top_o,   (q.size() == 0) ? 32'h0 : q[q.size()-1]);
    chk({tag, "_empty"}, {31'b0, rsb_empty_o}, {31'b0, q.size() == 0});
    chk({tag, "_full"},  {31'b0, rsb_full_o},  {31'b0, q.size() == DEPTH});
    chk({tag, "_pc"},    rsb_pc_o,    m_pc);
    chk({tag, "_valid"}, {31'b0, rsb_valid_o}, {31'b0, m_valid});
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                      input logic st, input logic fl, input string tag);
    if_valid_i = v; if_insn_i = insn; if_pc_i = pc; stall_i = st; flush_i = fl;
    @(posedge clk_i);
    #1;
    model(v, insn, pc, st, fl);
    check_all(tag);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [31:0] rets [4];
    rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0; if_valid_i = 1'b0;
    if_pc_i = '0; if_insn_i = '0;
    m_pc = '0; m_valid = 1'b0;
    #3;
    chk("rst_pc", rsb_pc_o, 32'h0);
    chk("rst_valid", {31'b0, rsb_valid_o}, 32'h0);
    chk("rst_empty", {31'b0, rsb_empty_o}, 32'h1);
    chk("rst_full", {31'b0, rsb_full_o}, 32'h0);
    chk("rst_top", rsb_top_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Call then return
    step(1, jal(5'd1), 32'h100, 0, 0, "call");
    chk("call_top_c", rsb_top_o, 32'h104);
    step(1, jalr(5'd0, 5'd1), 32'h180, 0, 0, "ret");
    chk("ret_pc_c", rsb_pc_o, 32'h104);
    chk("ret_valid_c", {31'b0, rsb_valid_o}, 32'h1);
    chk("ret_empty_c", {31'b0, rsb_empty_o}, 32'h1);

    // Overflow with five calls, then drain
`ifdef RISCV_RSB_OVERWRITE_EN
    rets = '{32'h54, 32'h44, 32'h34, 32'h24};
`else
    rets = '{32'h44, 32'h34, 32'h24, 32'h14};
`endif
    for (int i = 1; i <= 5; i++) step(1, jal(5'd1), 32'(i * 16), 0, 0, "ovf_call");
    chk("ovf_full_c", {31'b0, rsb_full_o}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1, jalr(5'd0, 5'd5), 32'h900, 0, 0, "ovf_ret");
      chk("ovf_ret_c", rsb_pc_o, rets[i]);
    end
    step(1, jalr(5'd0, 5'd1), 32'h900, 0, 0, "under");
    chk("under_valid_c", {31'b0, rsb_valid_o}, 32'h0);
    chk("under_pc_c", rsb_pc_o, 32'h0);

    // Pop+push replaces top in place; rd==rs1 is push only
    step(1, jal(5'd1), 32'h200, 0, 0, "pp_setup");
    step(1, jalr(5'd1, 5'd5), 32'h300, 0, 0, "pp");
    chk("pp_pc_c", rsb_pc_o, 32'h204);
    chk("pp_top_c", rsb_top_o, 32'h304);
    step(1, jalr(5'd5, 5'd5), 32'h400, 0, 0, "same");
    chk("same_top_c", rsb_top_o, 32'h404);
    chk("same_valid_c", {31'b0, rsb_valid_o}, 32'h0);

    // Return held under stall
    for (int i = 0; i < 3; i++) step(1, jalr(5'd0, 5'd1), 32'h500, 1, (i == 1), "stall");
    chk("stall_top_c", rsb_top_o, 32'h404);
    step(1, jalr(5'd0, 5'd1), 32'h500, 0, 0, "unstall");
    chk("unstall_pc_c", rsb_pc_o, 32'h404);
    chk("unstall_top_c", rsb_top_o, 32'h304);

    // Flush with a concurrent call
    step(1, jal(5'd1), 32'h600, 0, 0, "fl_call");
    step(1, jal(5'd5), 32'h700, 0, 0, "fl_call");
    step(1, jal(5'd1), 32'h800, 0, 1, "flush");
    chk("flush_empty_c", {31'b0, rsb_empty_o}, 32'h1);
    step(1, jalr(5'd0, 5'd1), 32'h880, 0, 0, "fl_ret");
    chk("fl_ret_valid_c", {31'b0, rsb_valid_o}, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] insn, pc;
      int k;
      k = $urandom_range(0, 9);
      if (k < 4)      insn = jal(pick_reg()) | ($urandom() & 32'hFFFF_F000);
      else if (k < 9) insn = jalr(pick_reg(), pick_reg()) | ($urandom() & 32'hFFF0_0000);
      else            insn = $urandom();
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      step($urandom_range(0, 9) != 0, insn, pc, $urandom_range(0, 4) == 0,
           $urandom_range(0, 24) == 0, "rnd");
    end

    // Asynchronous reset mid-operation
    step(1, jal(5'd1), 32'hA00, 0, 0, "pre_rst");
    step(1, jal(5'd1), 32'hB00, 0, 0, "pre_rst");
    step(1, jalr(5'd0, 5'd1), 32'hC00, 0, 0, "pre_rst");
    #1;
    rst_ni = 1'b0;
    #1;
    q.delete(); m_pc = '0; m_valid = 1'b0;
    check_all("arst");
    chk("arst_top_c", rsb_top_o, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    step(1, jalr(5'd0, 5'd1), 32'hD00, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
